// File: rtl/clock_set_ctrl.sv
// hh:mm:ss timekeeping with a two-button set interface.
// Mode button steps the set field; inc button bumps it with auto-repeat.
module clock_set_ctrl #(
  parameter int REPEAT_DLY = 8,
  parameter int REPEAT_PER = 4
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hr,
  output logic [1:0] mode,
  output logic       setting,
  output logic       day_pulse
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } mode_e;

  localparam int MAXL = (REPEAT_DLY > REPEAT_PER) ?
                        REPEAT_DLY : REPEAT_PER;
  localparam int CW = $clog2(MAXL + 1);
  localparam logic [CW-1:0] DLY_C = CW'(REPEAT_DLY);
  localparam logic [CW-1:0] PER_C = CW'(REPEAT_PER);

  mode_e         state_q, state_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hr_q, hr_d;
  logic          set_q, set_d;
  logic          dp_q, dp_d;
  logic          mb_q, ib_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rpt_q, rpt_d;
  logic          blk_q, blk_d;

  logic          mode_ev;
  logic          inc_edge;
  logic          inc_ev;
  logic [CW-1:0] lim;

  assign mode_ev  = mode_btn & ~mb_q;
  assign inc_edge = inc_btn & ~ib_q;
  assign lim      = rpt_q ? PER_C : DLY_C;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= RUN;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      set_q   <= 1'b0;
      dp_q    <= 1'b0;
      mb_q    <= 1'b0;
      ib_q    <= 1'b0;
      cnt_q   <= '0;
      rpt_q   <= 1'b0;
      blk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      set_q   <= set_d;
      dp_q    <= dp_d;
      mb_q    <= mode_btn;
      ib_q    <= inc_btn;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    dp_d    = 1'b0;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    blk_d   = blk_q;
    inc_ev  = 1'b0;

    // cnt counts held cycles; rpt selects first delay vs repeat period
    if (!inc_btn) begin
      cnt_d = '0;
      rpt_d = 1'b0;
      blk_d = 1'b0;
    end else if (inc_edge) begin
      cnt_d  = CW'(1);
      rpt_d  = 1'b0;
      blk_d  = 1'b0;
      inc_ev = 1'b1;
    end else if (!blk_q) begin
      if (cnt_q == lim) begin
        inc_ev = 1'b1;
        cnt_d  = CW'(1);
        rpt_d  = 1'b1;
      end else if (cnt_q < lim) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (mode_ev) begin
      unique case (state_q)
        RUN:     state_d = SET_HR;
        SET_HR:  state_d = SET_MIN;
        SET_MIN: state_d = SET_SEC;
        SET_SEC: state_d = RUN;
      endcase
      // a held inc_btn stays inert until released
      cnt_d = '0;
      rpt_d = 1'b0;
      blk_d = inc_btn;
    end

    if (state_q == RUN) begin
      if (tick) begin
        if (sec_q == 6'd59) begin
          sec_d = '0;
          if (min_q == 6'd59) begin
            min_d = '0;
            if (hr_q == 5'd23) begin
              hr_d = '0;
              dp_d = 1'b1;
            end else begin
              hr_d = hr_q + 5'd1;
            end
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end
    end else if (inc_ev && !mode_ev) begin
      unique case (state_q)
        SET_HR:
          hr_d = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        SET_MIN:
          min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        SET_SEC:
          sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
        default: ;
      endcase
    end

    set_d = (state_d != RUN);
  end

  assign sec       = sec_q;
  assign min       = min_q;
  assign hr        = hr_q;
  assign mode      = state_q;
  assign setting   = set_q;
  assign day_pulse = dp_q;

endmodule
